// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback vs. queued long-unit
// results, with a starvation counter that forces a drain stall.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_regw,
  input  logic                          wb_memtoreg,
  input  logic [DATA_W-1:0]             wb_mem_data,
  input  logic [DATA_W-1:0]             wb_alu_data,
  input  logic [ADDR_W-1:0]             wb_rd,
  input  logic                          lu_valid,
  input  logic [DATA_W-1:0]             lu_data,
  input  logic [ADDR_W-1:0]             lu_rd,
  output logic                          lu_ready,
  output logic                          rf_we,
  output logic [ADDR_W-1:0]             rf_wa,
  output logic [DATA_W-1:0]             rf_wd,
  output logic                          stall_pipe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_a [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [SW-1:0]     starve, starve_nx;
  logic [CW-1:0]     count_nx;
  logic [ADDR_W-1:0] wa_nx;
  logic [DATA_W-1:0] wd_nx;
  logic              push, pop, grant;
  logic              pipe_req, empty, last;

  assign lu_ready   = fifo_count < CW'(FIFO_DEPTH);
  assign push       = lu_valid && lu_ready;
  assign empty      = fifo_count == '0;
  assign pipe_req   = wb_regw && (wb_rd != '0);
  assign stall_pipe = state == FORCE;
  // FORCE always pops, so it ends when the last entry leaves with no refill
  assign last       = (fifo_count == CW'(1)) && !push;

  always_comb begin
    state_nx  = state;
    starve_nx = starve;
    pop       = 1'b0;
    grant     = 1'b0;
    wa_nx     = rf_wa;
    wd_nx     = rf_wd;
    unique case (state)
      NORMAL: begin
        if (pipe_req) begin
          grant = 1'b1;
          wa_nx = wb_rd;
          wd_nx = wb_memtoreg ? wb_mem_data : wb_alu_data;
        end else if (!empty) begin
          pop = 1'b1;
        end
        if (empty || pop) begin
          starve_nx = '0;
        end else if (starve == SW'(STARVE_MAX - 1)) begin
          starve_nx = '0;
          state_nx  = FORCE;
        end else begin
          starve_nx = starve + 1'b1;
        end
      end
      FORCE: begin
        pop       = 1'b1;
        starve_nx = '0;
        if (last) state_nx = NORMAL;
      end
    endcase
    // rd=0 entries are dropped without touching the register file
    if (pop && (mem_a[rd_ptr] != '0)) begin
      grant = 1'b1;
      wa_nx = mem_a[rd_ptr];
      wd_nx = mem_d[rd_ptr];
    end
  end

  always_comb begin
    count_nx = fifo_count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= NORMAL;
      starve     <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      rf_we      <= 1'b0;
      rf_wa      <= '0;
      rf_wd      <= '0;
    end else begin
      state      <= state_nx;
      starve     <= starve_nx;
      fifo_count <= count_nx;
      rf_we      <= grant;
      rf_wa      <= wa_nx;
      rf_wd      <= wd_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wr_ptr] <= lu_data;
      mem_a[wr_ptr] <= lu_rd;
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between the pipeline writeback stage (MEM/WB register outputs) and a long-latency unit (multiply/divide) result stream.
- Long-unit results are buffered in a small FIFO and drained whenever the pipeline leaves the port free.
- A starvation counter forces a pipeline stall so queued results always drain.
- Sits between the MEM/WB pipeline register, the long-latency unit and the register file; its stall output freezes the MEM/WB register and all upstream stages.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register address width.
- FIFO_DEPTH, 4, long-unit result queue entries (power of two, >=2).
- STARVE_MAX, 8, consecutive denied cycles with a non-empty FIFO before a forced drain.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- wb_regw  input  1  pipeline writeback enable (RegW from MEM/WB).
- wb_memtoreg  input  1  1 = write memory data, 0 = write ALU result.
- wb_mem_data  input  DATA_W  memory read data from MEM/WB.
- wb_alu_data  input  DATA_W  ALU result from MEM/WB.
- wb_rd  input  ADDR_W  pipeline destination register.
- lu_valid  input  1  long unit presents a result.
- lu_data  input  DATA_W  long-unit result.
- lu_rd  input  ADDR_W  long-unit destination register.
- lu_ready  output  1  FIFO accepts a result this cycle.
- rf_we  output  1  register-file write enable.
- rf_wa  output  ADDR_W  register-file write address.
- rf_wd  output  DATA_W  register-file write data.
- stall_pipe  output  1  freeze MEM/WB and upstream stages.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, immediate): rf_we=0, rf_wa=0, rf_wd=0, stall_pipe=0, fifo_count=0, state=NORMAL, starve counter=0, FIFO pointers=0. lu_ready=1 after reset.
- lu_ready = (fifo_count < FIFO_DEPTH), combinational; there is no same-cycle bypass when full.
- Push: lu_valid && lu_ready at a rising edge. Push and pop in the same cycle leave fifo_count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Pipeline request: wb_regw && wb_rd != 0. The pipeline data is wb_mem_data if wb_memtoreg=1, else wb_alu_data.
- rf_we/rf_wa/rf_wd are registered: the grant decided in cycle N appears in cycle N+1, held for one cycle only. rf_we=0 in any cycle with no grant; rf_wa/rf_wd then hold their previous values.
- State NORMAL (stall_pipe=0):
  - Pipeline request present: grant the pipeline.
  - Else FIFO non-empty: pop the head. rf_we=1 only if head rd != 0; an rd=0 entry is popped and discarded.
  - Starve counter increments when the FIFO is non-empty and the pipeline took the port. It clears on any pop or when the FIFO is empty.
  - When the counter would reach STARVE_MAX: go to FORCE, stall_pipe=1 from the next cycle, counter clears.
- State FORCE (stall_pipe=1):
  - wb_* inputs are ignored; the frozen MEM/WB register re-presents the same values after the stall.
  - Pop one entry per cycle.
  - Pushes are still accepted.
  - When the post-update count is 0: return to NORMAL, stall_pipe=0 from the next cycle.
  - Entry into FORCE with the FIFO already empty cannot happen.
- No ordering or hazard check between pipeline and FIFO destinations; ordering is owned by the issue scoreboard.
- Reset mid-FORCE: FIFO contents are discarded and stall_pipe drops immediately.

Test Plan:
- Reset, then pipeline request wb_regw=1, wb_memtoreg=0, wb_alu_data=0x0000_00AA, wb_rd=5 -> next cycle rf_we=1, rf_wa=5, rf_wd=0xAA; then wb_memtoreg=1, wb_mem_data=0x1234 -> rf_wd=0x1234.
- wb_regw=0, push lu_data=0xDEAD_BEEF, lu_rd=9 -> fifo_count=1, then rf_we=1, rf_wa=9, rf_wd=0xDEADBEEF, fifo_count=0. Repeat with lu_rd=0 -> entry popped, rf_we stays 0.
- Push 4 results while wb_regw=1 every cycle -> lu_ready=0 at count 4; a 5th lu_valid is not accepted; count stays 4.
- Continuous pipeline requests with 2 FIFO entries -> after 8 denied cycles stall_pipe=1; the 2 entries drain in order on consecutive cycles; stall_pipe=0 the cycle after the count reaches 0; the pipeline write then completes.
- Push and pop in the same cycle at count 2 -> count stays 2, FIFO order preserved across pointer wrap (push 6 entries total, verify rf_wa sequence).
- Assert rst during FORCE with count 3 -> stall_pipe=0, fifo_count=0, rf_we=0 immediately; lu_ready=1.
